// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_ERR        = 2'd3
  } pipe_state_e;

  localparam logic [4:0] REG_X0   = 5'd0;
  localparam int         ST_CNT_W = 3;

  function automatic logic is_load_use(input logic mem_read, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return mem_read && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_watchdog.sv
// Memory-wait watchdog: counts unready cycles, flags expiry at MEM_TIMEOUT (0 = never).
module hazard_watchdog #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_run,
  input  logic i_clear,
  output logic o_expired
);

  localparam int WD_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  logic [WD_W-1:0] r_wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (i_clear) begin
      r_wd_cnt <= '0;
    end else if (i_start) begin
      r_wd_cnt <= WD_W'(1);
    end else if (i_run && (r_wd_cnt != {WD_W{1'b1}})) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  assign o_expired = (MEM_TIMEOUT != 0) && (r_wd_cnt == WD_W'(MEM_TIMEOUT));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flush, memory freeze.
// Optional HAZARD_PERF_EN adds Stall_Cnt/Flush_Cnt performance counters.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int LOAD_USE_STALLS = 1,
  parameter int MEM_TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  IFID_Rs1,
  input  logic [4:0]  IFID_Rs2,
  input  logic [4:0]  IDEX_Rd,
  input  logic        IDEX_MemRead,
  input  logic        Branch_Taken,
  input  logic        Mem_Req,
  input  logic        Mem_Ready,
  input  logic        Err_Clear,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Write,
  output logic        EXMEM_Write,
  output logic        Ctrl,
  output logic        Mem_Timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] Stall_Cnt,
  output logic [31:0] Flush_Cnt
`endif
);

  localparam logic [ST_CNT_W-1:0] ST_LOAD = ST_CNT_W'(LOAD_USE_STALLS - 1);

  pipe_state_e         r_state, w_next_state;
  pipe_state_e         r_ret, w_next_ret;
  logic [ST_CNT_W-1:0] r_st_cnt, w_next_st_cnt;

  logic w_hazard, w_memwait;
  logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_write, w_exmem_write, w_ctrl, w_timeout;
  logic w_wd_start, w_wd_run, w_wd_clear, w_wd_expired;

  assign w_hazard  = is_load_use(IDEX_MemRead, IDEX_Rd, IFID_Rs1, IFID_Rs2);
  assign w_memwait = Mem_Req & ~Mem_Ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_ret    <= ST_RUN;
      r_st_cnt <= '0;
    end else begin
      r_state  <= w_next_state;
      r_ret    <= w_next_ret;
      r_st_cnt <= w_next_st_cnt;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_ret    = r_ret;
    w_next_st_cnt = r_st_cnt;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_write  = 1'b1;
    w_exmem_write = 1'b1;
    w_ctrl        = 1'b0;
    w_timeout     = 1'b0;
    w_wd_start    = 1'b0;
    w_wd_run      = 1'b0;
    w_wd_clear    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_memwait) begin
          {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = 4'b0000;
          w_next_state = ST_MEM_WAIT;
          w_next_ret   = ST_RUN;
          w_wd_start   = 1'b1;
        end else if (Branch_Taken) begin
          // The hazard's consumer sits in IF/ID and is flushed, so no bubble is needed.
          w_ifid_flush = 1'b1;
          w_ctrl       = 1'b1;
        end else if (w_hazard) begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_ctrl       = 1'b1;
          if (LOAD_USE_STALLS > 1) begin
            w_next_state  = ST_LOAD_STALL;
            w_next_st_cnt = ST_LOAD;
          end
        end
      end
      ST_LOAD_STALL: begin
        if (w_memwait) begin
          {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = 4'b0000;
          w_next_state = ST_MEM_WAIT;
          w_next_ret   = ST_LOAD_STALL;
          w_wd_start   = 1'b1;
        end else begin
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_ctrl       = 1'b1;
          if (r_st_cnt == ST_CNT_W'(1)) begin
            w_next_state  = ST_RUN;
            w_next_st_cnt = '0;
          end else begin
            w_next_st_cnt = r_st_cnt - ST_CNT_W'(1);
          end
        end
      end
      ST_MEM_WAIT: begin
        // Freeze holds on the completing cycle too; the access retires on the next edge.
        {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = 4'b0000;
        if (!w_memwait) begin
          w_next_state = r_ret;
          w_wd_clear   = 1'b1;
        end else if (w_wd_expired) begin
          w_next_state = ST_ERR;
        end else begin
          w_wd_run = 1'b1;
        end
      end
      ST_ERR: begin
        {w_pc_write, w_ifid_write, w_idex_write, w_exmem_write} = 4'b0000;
        w_ctrl    = 1'b1;
        w_timeout = 1'b1;
        if (Err_Clear) begin
          w_next_state  = ST_RUN;
          w_next_ret    = ST_RUN;
          w_next_st_cnt = '0;
          w_wd_clear    = 1'b1;
        end
      end
      default: w_next_state = ST_RUN;
    endcase
  end

  hazard_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_wd_start),
    .i_run    (w_wd_run),
    .i_clear  (w_wd_clear),
    .o_expired(w_wd_expired)
  );

  // Reset forces the pipeline quiescent with a bubble selected, without waiting for a clock.
  assign PCWrite     = rst_n & w_pc_write;
  assign IFID_Write  = rst_n & w_ifid_write;
  assign IFID_Flush  = rst_n & w_ifid_flush;
  assign IDEX_Write  = rst_n & w_idex_write;
  assign EXMEM_Write = rst_n & w_exmem_write;
  assign Ctrl        = ~rst_n | w_ctrl;
  assign Mem_Timeout = rst_n & w_timeout;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_write && (r_state != ST_ERR)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_ifid_flush)                       r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign Stall_Cnt = r_stall_cnt;
  assign Flush_Cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (1 bubble / no practical timeout, 3 bubbles / timeout 8)
// driven by shared directed + random stimulus and checked against a bubble/wait-count reference model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] i_rs1 = '0, i_rs2 = '0, i_rd = '0;
  logic       i_mr = 1'b0, i_br = 1'b0, i_mreq = 1'b0, i_mrdy = 1'b0, i_eclr = 1'b0;

  logic a_pc, a_ifw, a_fl, a_idw, a_exw, a_ctrl, a_to;
  logic b_pc, b_ifw, b_fl, b_idw, b_exw, b_ctrl, b_to;
`ifdef HAZARD_PERF_EN
  logic [31:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.LOAD_USE_STALLS(1), .MEM_TIMEOUT(255)) dut_a (
    .clk(clk), .rst_n(rst_n), .IFID_Rs1(i_rs1), .IFID_Rs2(i_rs2), .IDEX_Rd(i_rd),
    .IDEX_MemRead(i_mr), .Branch_Taken(i_br), .Mem_Req(i_mreq), .Mem_Ready(i_mrdy),
    .Err_Clear(i_eclr), .PCWrite(a_pc), .IFID_Write(a_ifw), .IFID_Flush(a_fl),
    .IDEX_Write(a_idw), .EXMEM_Write(a_exw), .Ctrl(a_ctrl), .Mem_Timeout(a_to)
`ifdef HAZARD_PERF_EN
    , .Stall_Cnt(a_stall_cnt), .Flush_Cnt(a_flush_cnt)
`endif
  );

  pipeline_hazard_ctrl #(.LOAD_USE_STALLS(3), .MEM_TIMEOUT(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .IFID_Rs1(i_rs1), .IFID_Rs2(i_rs2), .IDEX_Rd(i_rd),
    .IDEX_MemRead(i_mr), .Branch_Taken(i_br), .Mem_Req(i_mreq), .Mem_Ready(i_mrdy),
    .Err_Clear(i_eclr), .PCWrite(b_pc), .IFID_Write(b_ifw), .IFID_Flush(b_fl),
    .IDEX_Write(b_idw), .EXMEM_Write(b_exw), .Ctrl(b_ctrl), .Mem_Timeout(b_to)
`ifdef HAZARD_PERF_EN
    , .Stall_Cnt(b_stall_cnt), .Flush_Cnt(b_flush_cnt)
`endif
  );

  wire [6:0] w_out_a = {a_pc, a_ifw, a_fl, a_idw, a_exw, a_ctrl, a_to};
  wire [6:0] w_out_b = {b_pc, b_ifw, b_fl, b_idw, b_exw, b_ctrl, b_to};

  // Output vectors {PCWrite, IFID_Write, IFID_Flush, IDEX_Write, EXMEM_Write, Ctrl, Mem_Timeout}
  localparam logic [6:0] V_NORMAL = 7'b1101100;
  localparam logic [6:0] V_STALL  = 7'b0001110;
  localparam logic [6:0] V_BRANCH = 7'b1111110;
  localparam logic [6:0] V_FREEZE = 7'b0000000;
  localparam logic [6:0] V_ERR    = 7'b0000011;
  localparam logic [6:0] V_RESET  = 7'b0000010;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bubbles still owed, length of the current unready run, error latch.
  int m_lus[2] = '{1, 3};
  int m_tmo[2] = '{255, 8};
  int m_bub[2];
  int m_wlen[2];
  bit m_wait[2];
  bit m_err[2];
  int m_stall[2];
  int m_flush[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit in_memwait();
    return i_mreq && !i_mrdy;
  endfunction

  function automatic bit in_hazard();
    return i_mr && (i_rd != 5'd0) && ((i_rd == i_rs1) || (i_rd == i_rs2));
  endfunction

  function automatic logic [6:0] exp_out(input int k);
    if (m_err[k]) return V_ERR;
    if (m_wait[k] || in_memwait()) return V_FREEZE;
    if (m_bub[k] > 0) return V_STALL;
    if (i_br) return V_BRANCH;
    if (in_hazard()) return V_STALL;
    return V_NORMAL;
  endfunction

  task automatic mdl_reset();
    for (int k = 0; k < 2; k++) begin
      m_bub[k] = 0; m_wlen[k] = 0; m_wait[k] = 0; m_err[k] = 0;
      m_stall[k] = 0; m_flush[k] = 0;
    end
  endtask

  task automatic mdl_clock(input int k);
    logic [6:0] e;
    e = exp_out(k);
    if (!e[6] && !e[0]) m_stall[k]++;
    if (e[4]) m_flush[k]++;
    if (m_err[k]) begin
      if (i_eclr) m_err[k] = 0;
    end else if (m_wait[k]) begin
      if (!in_memwait()) begin
        m_wait[k] = 0; m_wlen[k] = 0;
      end else if (m_tmo[k] != 0 && m_wlen[k] == m_tmo[k]) begin
        // This unready cycle is number MEM_TIMEOUT+1 of the run: give up.
        m_err[k] = 1; m_wait[k] = 0; m_wlen[k] = 0; m_bub[k] = 0;
      end else begin
        m_wlen[k]++;
      end
    end else if (in_memwait()) begin
      m_wait[k] = 1; m_wlen[k] = 1;
    end else if (m_bub[k] > 0) begin
      m_bub[k]--;
    end else if (!i_br && in_hazard()) begin
      m_bub[k] = m_lus[k] - 1;
    end
  endtask

  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic mr, input logic br, input logic mreq, input logic mrdy,
                      input logic eclr);
    i_rs1 = rs1; i_rs2 = rs2; i_rd = rd; i_mr = mr; i_br = br;
    i_mreq = mreq; i_mrdy = mrdy; i_eclr = eclr;
    @(negedge clk);
    chk("out_a", {25'd0, w_out_a}, {25'd0, exp_out(0)});
    chk("out_b", {25'd0, w_out_b}, {25'd0, exp_out(1)});
    @(posedge clk);
    mdl_clock(0);
    mdl_clock(1);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    mdl_reset();
    #3;
    chk("reset_a", {25'd0, w_out_a}, {25'd0, V_RESET});
    chk("reset_b", {25'd0, w_out_b}, {25'd0, V_RESET});
`ifdef HAZARD_PERF_EN
    chk("reset_stall_cnt", a_stall_cnt, 32'd0);
`endif
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Load-use on rs2, then cleared
    step(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // Load into x0 never stalls; then load-use on rs1
    step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(4);
    // Branch together with a load-use hazard
    step(5'd9, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    // Four unready cycles, then ready
    for (int i = 0; i < 4; i++) step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    // Memory wait injected in the middle of the 3-bubble stall
    step(5'd4, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(4);
    // Watchdog: held unready long enough for the 8-cycle instance to time out
    for (int i = 0; i < 12; i++) step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Asynchronous reset in the middle of a memory wait
    for (int i = 0; i < 2; i++) step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_a", {25'd0, w_out_a}, {25'd0, V_RESET});
    chk("async_reset_b", {25'd0, w_out_b}, {25'd0, V_RESET});
`ifdef HAZARD_PERF_EN
    chk("async_reset_stall_cnt", a_stall_cnt, 32'd0);
`endif
    mdl_reset();
    i_mreq = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(2);

    for (int i = 0; i < 800; i++) begin
      step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 20),
           1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 99) < 40),
           1'($urandom_range(0, 99) < 25));
    end
    // Long unready run during random phase to revisit the timeout
    for (int i = 0; i < 11; i++) step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);

`ifdef HAZARD_PERF_EN
    chk("stall_cnt_a", a_stall_cnt, 32'(m_stall[0]));
    chk("flush_cnt_a", a_flush_cnt, 32'(m_flush[0]));
    chk("stall_cnt_b", b_stall_cnt, 32'(m_stall[1]));
    chk("flush_cnt_b", b_flush_cnt, 32'(m_flush[1]));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the bubble select (Ctrl) of the ID/EX control-zeroing mux, the PC and pipeline-register write enables, and the IF/ID flush. It handles load-use hazards (configurable stall depth), taken-branch flushes and data-memory wait states, with a watchdog on memory waits.

Parameters:
LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1..7)
MEM_TIMEOUT, 255, maximum Mem_Req-without-Mem_Ready cycles before error; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
IFID_Rs1  in  5  rs1 of the instruction in ID
IFID_Rs2  in  5  rs2 of the instruction in ID
IDEX_Rd  in  5  rd of the instruction in EX
IDEX_MemRead  in  1  instruction in EX is a load
Branch_Taken  in  1  branch/jump resolved taken in EX
Mem_Req  in  1  MEM stage is accessing data memory
Mem_Ready  in  1  data memory completes access this cycle
Err_Clear  in  1  leave ERR state
PCWrite  out  1  PC register enable
IFID_Write  out  1  IF/ID register enable
IFID_Flush  out  1  IF/ID register loads NOP
IDEX_Write  out  1  ID/EX register enable
EXMEM_Write  out  1  EX/MEM and MEM/WB enables
Ctrl  out  1  1 = zero control signals into ID/EX (bubble)
Mem_Timeout  out  1  watchdog fired; high while in ERR

Behaviour:
- Clock clk; reset rst_n is asynchronous, active-low. While rst_n=0: state=RUN, counters=0; outputs PCWrite=0, IFID_Write=0, IDEX_Write=0, EXMEM_Write=0, IFID_Flush=0, Ctrl=1, Mem_Timeout=0. The first edge after release runs in RUN.
- Outputs are combinational from state and current inputs (Mealy), giving zero-latency stalls. Default (no event): all write enables=1, Ctrl=0, IFID_Flush=0.
- hazard = IDEX_MemRead & (IDEX_Rd!=0) & (IDEX_Rd==IFID_Rs1 | IDEX_Rd==IFID_Rs2).
- memwait = Mem_Req & ~Mem_Ready.
- Priority in RUN: memwait > Branch_Taken > hazard.
- RUN, memwait: PCWrite=IFID_Write=IDEX_Write=EXMEM_Write=0, Ctrl=0. Go to MEM_WAIT with wd_cnt=1 and ret=RUN.
- RUN, Branch_Taken: PCWrite=1, IFID_Flush=1, Ctrl=1. Any simultaneous hazard is ignored because its consumer is flushed. Stay in RUN.
- RUN, hazard: PCWrite=0, IFID_Write=0, Ctrl=1. If LOAD_USE_STALLS>1, go to LOAD_STALL with st_cnt=LOAD_USE_STALLS-1; otherwise stay in RUN.
- LOAD_STALL: same outputs as the hazard case, independent of the hazard inputs. Branch_Taken is ignored (EX holds a bubble). st_cnt decrements each cycle; at st_cnt==1 the next state is RUN. memwait takes priority: freeze outputs as in MEM_WAIT, st_cnt held, ret=LOAD_STALL.
- MEM_WAIT: full freeze (all write enables=0, Ctrl=0, IFID_Flush=0).
  - On Mem_Ready=1 (or Mem_Req=0): the freeze still holds that cycle; next state=ret.
  - Otherwise wd_cnt increments, saturating. If MEM_TIMEOUT!=0 and wd_cnt==MEM_TIMEOUT with Mem_Ready still 0, next state=ERR.
- ERR: all write enables=0, Ctrl=1, Mem_Timeout=1. Err_Clear=1 gives next state RUN with counters cleared. Only rst_n or Err_Clear exits ERR.
- Counter widths: st_cnt 3 bits; wd_cnt $clog2(MEM_TIMEOUT+1) bits, minimum 1.
- Reset asserted mid-stall or mid-wait aborts immediately to reset values; no pending state survives.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: adds outputs Stall_Cnt[31:0] (cycles with PCWrite=0 in RUN/LOAD_STALL/MEM_WAIT) and Flush_Cnt[31:0] (cycles with IFID_Flush=1). Both are wrapping counters, reset to 0 by rst_n only.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package riscv_pipe_pkg: state enum (RUN, LOAD_STALL, MEM_WAIT, ERR), REG_X0=5'd0, localparam ST_CNT_W=3.
- One sub-module, hazard_watchdog: wd_cnt plus timeout compare, parameterised by MEM_TIMEOUT. Its inputs are start/run/clear; its output is expired.

Test Plan:
1. Load-use, LOAD_USE_STALLS=1: IDEX_MemRead=1, IDEX_Rd=5, IFID_Rs2=5 for 1 cycle -> that cycle PCWrite=0, IFID_Write=0, Ctrl=1; next cycle (hazard cleared) all enables=1, Ctrl=0.
2. Load-use with LOAD_USE_STALLS=3 and IDEX_Rd=0 -> no stall. Then IDEX_Rd=7=IFID_Rs1 -> exactly 3 consecutive cycles with Ctrl=1 and PCWrite=0.
3. Branch_Taken=1 together with a load-use hazard -> IFID_Flush=1, Ctrl=1, PCWrite=1, no LOAD_STALL entry; next cycle normal.
4. Mem_Req=1, Mem_Ready=0 for 4 cycles then 1 -> 5 frozen cycles (all enables 0, Ctrl=0), then normal. memwait injected during LOAD_STALL (LOAD_USE_STALLS=3) -> remaining bubbles resume after the wait.
5. MEM_TIMEOUT=8, Mem_Req=1, Mem_Ready=0 held -> ERR, Mem_Timeout=1 after 8 wait cycles. Err_Clear pulse -> RUN next cycle, Mem_Timeout=0.
6. rst_n asserted mid MEM_WAIT -> outputs go to reset values asynchronously, before the next clock edge. With HAZARD_PERF_EN defined: Stall_Cnt=0 after reset; after scenario 1 Stall_Cnt=1, after scenario 3 Flush_Cnt=1.
